muldiv_arbiter: RTL and testbench

Shares one iterative 16-bit multiply/divide engine between `N_REQ` requesting execute stages, such as the execute stages of several CPU cores. It arbitrates round-robin, sequences the 16 fixed iterations of the selected operation, and returns the result to the winning requester with a one-cycle response pulse. Single-cycle ALU operations stay inside each execute stage; only MUL/MULI/DIV/DIVI are routed here.

---
 rtl/muldiv_pkg.sv | 11 +
 rtl/muldiv_core.sv | 71 +++++++
 rtl/muldiv_arbiter.sv | 134 +++++++++++++
 tb/tb_muldiv_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the shared iterative multiply/divide engine.
package muldiv_pkg;

   typedef enum logic {OP_MUL, OP_DIV} muldiv_op_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} muldiv_state_t;

   localparam int MULDIV_ITER = 16;
   localparam int MULDIV_W    = 16;

endpackage

// File: rtl/muldiv_core.sv
// Iterative 16-bit shift-add multiplier / restoring divider; one iteration per un-held cycle.
// Operands load on start; done flags the final iteration; hold freezes every register.
module muldiv_core
   import muldiv_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                op,
   input  logic [MULDIV_W-1:0] a,
   input  logic [MULDIV_W-1:0] b,
   input  logic                hold,
   output logic                done,
   output logic [MULDIV_W-1:0] result,
   output logic                dbz
);

   muldiv_op_t          op_q;
   logic [MULDIV_W-1:0] a_q;
   logic [MULDIV_W-1:0] b_q;
   logic [MULDIV_W-1:0] acc_q;
   logic [MULDIV_W-1:0] rem_q;
   logic [4:0]          iter;

   logic [MULDIV_W:0]   rem_sh;
   logic [MULDIV_W-1:0] rem_sub;
   logic                div_bit;

   // a_q shifts left every iteration: it is A<<iter for MUL and exposes the next dividend bit for DIV.
   always_comb begin
      rem_sh  = {rem_q, a_q[MULDIV_W-1]};
      div_bit = (rem_sh >= {1'b0, b_q});
      rem_sub = rem_sh[MULDIV_W-1:0] - b_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q  <= OP_MUL;
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         rem_q <= '0;
         iter  <= '0;
      end else if (start) begin
         op_q  <= muldiv_op_t'(op);
         a_q   <= a;
         b_q   <= b;
         acc_q <= '0;
         rem_q <= '0;
         iter  <= '0;
      end else if (!hold) begin
         a_q <= a_q << 1;
         if (op_q == OP_MUL) begin
            if (b_q[iter[3:0]]) begin
               acc_q <= acc_q + a_q;
            end
         end else begin
            rem_q <= div_bit ? rem_sub : rem_sh[MULDIV_W-1:0];
            acc_q <= {acc_q[MULDIV_W-2:0], div_bit};
         end
         if (iter != 5'(MULDIV_ITER - 1)) begin
            iter <= iter + 5'd1;
         end
      end
   end

   assign done   = (iter == 5'(MULDIV_ITER - 1));
   assign dbz    = (op_q == OP_DIV) && (b_q == '0);
   assign result = dbz ? '1 : acc_q;

endmodule

// File: rtl/muldiv_arbiter.sv
// Round-robin share of one muldiv engine among N_REQ requesters; grant at T, result pulse at T+17.
// stall freezes everything, withholds grants and holds the response pulse off until released.
module muldiv_arbiter
   import muldiv_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_op,
   input  logic [N_REQ*MULDIV_W-1:0] req_a,
   input  logic [N_REQ*MULDIV_W-1:0] req_b,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          rsp_valid,
   output logic [MULDIV_W-1:0]       rsp_data,
   output logic                      rsp_div_by_zero,
   output logic                      busy
);

   muldiv_state_t       state_q;
   muldiv_state_t       state_d;
   logic [ID_W-1:0]     last_grant;
   logic [ID_W-1:0]     id_q;

   logic                win_vld;
   logic [ID_W-1:0]     win_id;
   logic [N_REQ-1:0]    win_oh;
   int                  pick_idx;

   logic                start;
   logic                core_hold;
   logic                core_done;
   logic [MULDIV_W-1:0] core_result;
   logic                core_dbz;
   logic                rsp_fire;

   logic [MULDIV_W-1:0] a_arr [N_REQ];
   logic [MULDIV_W-1:0] b_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign a_arr[g] = req_a[g*MULDIV_W +: MULDIV_W];
      assign b_arr[g] = req_b[g*MULDIV_W +: MULDIV_W];
   end

   // Search from last_grant+1 upward, wrapping, so the previous winner comes last.
   always_comb begin
      win_vld  = 1'b0;
      win_id   = '0;
      pick_idx = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         pick_idx = (int'(last_grant) + k) % N_REQ;
         if (!win_vld && req_valid[ID_W'(pick_idx)]) begin
            win_vld = 1'b1;
            win_id  = ID_W'(pick_idx);
         end
      end
      win_oh         = '0;
      win_oh[win_id] = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      req_ready = '0;
      unique case (state_q)
         IDLE: begin
            if (!stall && win_vld) begin
               req_ready = win_oh;
               start     = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (!stall && core_done) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!stall) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         last_grant <= ID_W'(N_REQ - 1);
         id_q       <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            id_q <= win_id;
         end
         if (rsp_fire) begin
            last_grant <= id_q;
         end
      end
   end

   assign core_hold = stall || (state_q != RUN);

   muldiv_core u_core (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (req_op[win_id]),
      .a      (a_arr[win_id]),
      .b      (b_arr[win_id]),
      .hold   (core_hold),
      .done   (core_done),
      .result (core_result),
      .dbz    (core_dbz)
   );

   assign rsp_fire = (state_q == DONE) && !stall;

   always_comb begin
      rsp_valid = '0;
      if (rsp_fire) begin
         rsp_valid[id_q] = 1'b1;
      end
   end

   assign rsp_data        = rsp_fire ? core_result : '0;
   assign rsp_div_by_zero = rsp_fire && core_dbz;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Randomised scoreboard bench for muldiv_arbiter with a cycle-level arbitration/latency model.
module tb_muldiv_arbiter;

   localparam int N = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           stall;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_op;
   logic [N*16-1:0] req_a;
   logic [N*16-1:0] req_b;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   rsp_valid;
   logic [15:0]    rsp_data;
   logic           rsp_div_by_zero;
   logic           busy;

   always #5 clk = ~clk;

   muldiv_arbiter #(.N_REQ(N)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .req_valid       (req_valid),
      .req_op          (req_op),
      .req_a           (req_a),
      .req_b           (req_b),
      .req_ready       (req_ready),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .rsp_div_by_zero (rsp_div_by_zero),
      .busy            (busy)
   );

   typedef struct {
      int          id;
      logic [15:0] data;
      logic        dbz;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t ref_op(input int id, input logic op, input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      logic [31:0] p;
      e.id = id;
      if (op == 1'b0) begin
         p      = {16'd0, a} * {16'd0, b};
         e.data = p[15:0];
         e.dbz  = 1'b0;
      end else if (b == 16'd0) begin
         e.data = 16'hFFFF;
         e.dbz  = 1'b1;
      end else begin
         e.data = a / b;
         e.dbz  = 1'b0;
      end
      return e;
   endfunction

   function automatic int rr_pick(input int last, input logic [N-1:0] v);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   // Model: the granted op answers on its 17th non-stalled cycle after the handshake.
   int  m_last = N - 1;
   bit  m_out  = 1'b0;
   int  m_cnt  = 0;
   int  m_id   = 0;

   always @(negedge clk) begin : monitor
      exp_t        e;
      int          w;
      logic [31:0] exp_rdy;
      if (rst) begin
         m_out  = 1'b0;
         m_cnt  = 0;
         m_last = N - 1;
         sb_q.delete();
      end else begin
         check("busy", {31'd0, busy}, {31'd0, m_out});
         if (m_out) begin
            check("req_ready_while_busy", {30'd0, req_ready}, 32'd0);
            if (!stall) m_cnt++;
            if (m_cnt == 17) begin
               check("rsp_valid_id", {30'd0, rsp_valid}, 32'd1 << m_id);
               if (sb_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL sb_underflow: response with no expected entry (t=%0t)", $time);
               end else begin
                  e = sb_q.pop_front();
                  check("rsp_valid_sb", {30'd0, rsp_valid}, 32'd1 << e.id);
                  check("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                  check("rsp_div_by_zero", {31'd0, rsp_div_by_zero}, {31'd0, e.dbz});
               end
               m_out  = 1'b0;
               m_last = m_id;
            end else begin
               check("rsp_valid_quiet", {30'd0, rsp_valid}, 32'd0);
               check("rsp_data_quiet", {16'd0, rsp_data}, 32'd0);
            end
         end else begin
            check("rsp_valid_idle", {30'd0, rsp_valid}, 32'd0);
            w       = stall ? -1 : rr_pick(m_last, req_valid);
            exp_rdy = (w < 0) ? 32'd0 : (32'd1 << w);
            check("req_ready", {30'd0, req_ready}, exp_rdy);
            if (w >= 0) begin
               m_out = 1'b1;
               m_cnt = 0;
               m_id  = w;
            end
         end
      end
   end

   // Presents one op, waits for its grant, pushes the expected result, returns in the cycle after the handshake.
   task automatic issue(input int id, input logic op, input logic [15:0] a, input logic [15:0] b,
                        input bit keep_valid);
      req_op[id]           = op;
      req_a[id*16 +: 16]   = a;
      req_b[id*16 +: 16]   = b;
      req_valid[id]        = 1'b1;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (req_valid[id] && req_ready[id]) begin
            sb_q.push_back(ref_op(id, op, a, b));
            @(posedge clk);
            #1;
            if (!keep_valid) req_valid[id] = 1'b0;
            return;
         end
      end
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: requester %0d got no req_ready within 300 cycles", id);
      req_valid[id] = 1'b0;
   endtask

   task automatic requester(input int id, input int n_ops, input bit back_to_back);
      logic        op;
      logic [15:0] a;
      logic [15:0] b;
      for (int i = 0; i < n_ops; i++) begin
         if (!back_to_back) begin
            repeat ($urandom_range(0, 25)) @(posedge clk);
            #1;
         end
         op = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
         case ($urandom_range(0, 5))
            0:       b = 16'd0;
            1, 2:    b = 16'($urandom_range(1, 20));
            default: b = 16'($urandom);
         endcase
         issue(id, op, a, b, back_to_back && (i != n_ops - 1));
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      stall     = 1'b0;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      settle(3);
      check("reset_req_ready", {30'd0, req_ready}, 32'd0);
      check("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      check("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
      check("reset_dbz", {31'd0, rsp_div_by_zero}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      settle(2);

      // Directed operations, including overflow and divide-by-zero corners.
      issue(0, 1'b0, 16'd7, 16'd6, 1'b0);           settle(20);
      issue(1, 1'b0, 16'h1234, 16'h0100, 1'b0);     settle(20);
      issue(0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);     settle(20);
      issue(1, 1'b1, 16'd100, 16'd7, 1'b0);         settle(20);
      issue(0, 1'b1, 16'd5, 16'd0, 1'b0);           settle(20);
      issue(1, 1'b1, 16'd0, 16'd3, 1'b0);           settle(20);

      // Stall 3 cycles at RUN iteration 5.
      issue(1, 1'b0, 16'd300, 16'd211, 1'b0);
      settle(5);
      stall = 1'b1;
      settle(3);
      stall = 1'b0;
      settle(20);

      // Stall across DONE.
      issue(0, 1'b1, 16'd50000, 16'd7, 1'b0);
      settle(16);
      stall = 1'b1;
      settle(4);
      stall = 1'b0;
      settle(8);

      // Request while stalled in IDLE.
      stall = 1'b1;
      fork
         issue(1, 1'b0, 16'd12, 16'd12, 1'b0);
         begin
            settle(4);
            stall = 1'b0;
         end
      join
      settle(20);

      // Both requesters continuously busy: strict alternation.
      fork
         requester(0, 8, 1'b1);
         requester(1, 8, 1'b1);
      join
      settle(20);

      // Random arrival with random stalls.
      fork
         requester(0, 10, 1'b0);
         requester(1, 10, 1'b0);
         begin
            repeat (400) begin
               @(posedge clk);
               #1;
               stall = ($urandom_range(0, 9) == 0);
            end
            stall = 1'b0;
         end
      join
      stall = 1'b0;
      settle(30);

      // Reset abort at RUN iteration 8, then simultaneous requests.
      issue(0, 1'b0, 16'h00FF, 16'h0101, 1'b0);
      settle(8);
      rst = 1'b1;
      settle(1);
      rst = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      check("abort_rsp_data", {16'd0, rsp_data}, 32'd0);
      check("abort_dbz", {31'd0, rsp_div_by_zero}, 32'd0);
      fork
         issue(0, 1'b1, 16'd1000, 16'd9, 1'b0);
         issue(1, 1'b0, 16'd250, 16'd4, 1'b0);
      join
      settle(30);

      check("sb_drained", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
